// File: rtl/lfsr_checker8.sv
// rtl/lfsr_checker8.sv - receive-side checker for the 8-bit Fibonacci LFSR stream
//
// Self-seeds a local reference from the incoming bits, acquires lock after
// LOCK_COUNT consecutive correct predictions, then free-runs the reference
// and counts bit errors. Too many errors within one observation window drop lock.
//
// Ports:
//   CLK        clock, all state updates on the rising edge
//   RESET      synchronous active-high reset, priority over every input
//   I          received serial bit
//   VALID      I carries a stream bit this cycle
//   CLEAR      clears ERR_COUNT (a coincident counted error leaves it at 1)
//   LOCKED     high while in the LOCKED state
//   ERR        one-cycle pulse per mismatched bit while LOCKED
//   ERR_COUNT  saturating count of LOCKED-state errors
//   STATE      0=SEED, 1=ACQUIRE, 2=LOCKED
module lfsr_checker8 #(
    parameter int LOCK_COUNT  = 16,
    parameter int WINDOW      = 32,
    parameter int UNLOCK_ERRS = 4,
    parameter int ERR_W       = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             I,
    input  logic             VALID,
    input  logic             CLEAR,
    output logic             LOCKED,
    output logic             ERR,
    output logic [ERR_W-1:0] ERR_COUNT,
    output logic [1:0]       STATE
);

    localparam logic [1:0] ST_SEED = 2'd0;
    localparam logic [1:0] ST_ACQ  = 2'd1;
    localparam logic [1:0] ST_LOCK = 2'd2;

    localparam int MC_W = $clog2(LOCK_COUNT + 1);
    localparam int WC_W = $clog2(WINDOW + 1);
    localparam int EC_W = $clog2(UNLOCK_ERRS + 1);

    localparam logic [MC_W-1:0] MATCH_LAST = MC_W'(LOCK_COUNT - 1);
    localparam logic [WC_W-1:0] WIN_LAST   = WC_W'(WINDOW - 1);
    localparam logic [EC_W-1:0] EW_LAST    = EC_W'(UNLOCK_ERRS - 1);

    // The prediction taps only reach back to h[4] and the bit shifted into
    // h[7] is never read afterwards, so only h[6:0] needs to be stored.
    logic [6:0]       h_q, h_d;
    logic [7:0]       h_new;
    logic [1:0]       state_q, state_d;
    logic [2:0]       seed_q, seed_d;
    logic [MC_W-1:0]  match_q, match_d;
    logic [WC_W-1:0]  win_q, win_d;
    logic [EC_W-1:0]  ew_q, ew_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [ERR_W-1:0] count_base;
    logic             p;
    logic             miss;

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        seed_d      = seed_q;
        match_d     = match_q;
        win_d       = win_q;
        ew_d        = ew_q;
        err_d       = 1'b0;
        p           = h_q[0] ^ h_q[2] ^ h_q[3] ^ h_q[4];
        miss        = I ^ p;
        h_new       = {h_q, I};
        // CLEAR is applied first so a coincident error lands on a zero base.
        count_base  = CLEAR ? '0 : err_count_q;
        err_count_d = count_base;

        if (VALID) begin
            case (state_q)
                ST_SEED: begin
                    h_d = h_new[6:0];
                    if (seed_q == 3'd7) begin
                        seed_d  = 3'd0;
                        match_d = '0;
                        if (|h_new) begin
                            state_d = ST_ACQ;
                        end
                    end else begin
                        seed_d = seed_q + 3'd1;
                    end
                end
                ST_ACQ: begin
                    h_d = {h_q[5:0], I};
                    if (!miss) begin
                        if (match_q == MATCH_LAST) begin
                            state_d = ST_LOCK;
                            match_d = '0;
                            win_d   = '0;
                            ew_d    = '0;
                        end else begin
                            match_d = match_q + MC_W'(1);
                        end
                    end else begin
                        state_d = ST_SEED;
                        seed_d  = 3'd0;
                        match_d = '0;
                    end
                end
                ST_LOCK: begin
                    // Shift the prediction, not I, so one flipped bit costs one error.
                    h_d = {h_q[5:0], p};
                    if (miss) begin
                        err_d = 1'b1;
                        if (count_base != '1) begin
                            err_count_d = count_base + ERR_W'(1);
                        end
                    end
                    // Unlock takes priority over window expiry on the same bit.
                    if (miss && (ew_q == EW_LAST)) begin
                        state_d = ST_SEED;
                        seed_d  = 3'd0;
                        match_d = '0;
                        win_d   = '0;
                        ew_d    = '0;
                    end else if (win_q == WIN_LAST) begin
                        win_d = '0;
                        ew_d  = '0;
                    end else begin
                        win_d = win_q + WC_W'(1);
                        if (miss) begin
                            ew_d = ew_q + EC_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_SEED;
                    seed_d  = 3'd0;
                    match_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            h_q         <= '0;
            state_q     <= ST_SEED;
            seed_q      <= '0;
            match_q     <= '0;
            win_q       <= '0;
            ew_q        <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            h_q         <= h_d;
            state_q     <= state_d;
            seed_q      <= seed_d;
            match_q     <= match_d;
            win_q       <= win_d;
            ew_q        <= ew_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign LOCKED    = (state_q == ST_LOCK);
    assign ERR       = err_q;
    assign ERR_COUNT = err_count_q;
    assign STATE     = state_q;

endmodule

// File: tb/tb_lfsr_checker8.sv
// tb/tb_lfsr_checker8.sv - directed self-checking bench for lfsr_checker8
module tb_lfsr_checker8;

    logic        CLK = 1'b0;
    logic        RESET, I, VALID, CLEAR;
    logic        locked, err, locked_s, err_s;
    logic [15:0] err_count;
    logic [3:0]  err_count_s;
    logic [1:0]  state, state_s;

    int          total  = 0;
    int          bad    = 0;
    int          pulses = 0;
    int          nlk    = 0;
    logic [7:0]  g;

    always #5 CLK = ~CLK;

    lfsr_checker8 u_dut (
        .CLK(CLK), .RESET(RESET), .I(I), .VALID(VALID), .CLEAR(CLEAR),
        .LOCKED(locked), .ERR(err), .ERR_COUNT(err_count), .STATE(state)
    );

    lfsr_checker8 #(.ERR_W(4)) u_sat (
        .CLK(CLK), .RESET(RESET), .I(I), .VALID(VALID), .CLEAR(CLEAR),
        .LOCKED(locked_s), .ERR(err_s), .ERR_COUNT(err_count_s), .STATE(state_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic b, input logic v, input logic clr, input logic rst);
        I     = b;
        VALID = v;
        CLEAR = clr;
        RESET = rst;
        @(posedge CLK);
        #1;
        if (err === 1'b1) pulses++;
    endtask

    // Generator: output g[0], shift right, feedback realises
    // b[n] = b[n-1] ^ b[n-3] ^ b[n-4] ^ b[n-5].
    task automatic tx(input logic flip, input logic clr);
        logic b;
        b = g[0];
        g = {g[7] ^ g[5] ^ g[4] ^ g[3], g[7:1]};
        nlk++;
        step(b ^ flip, 1'b1, clr, 1'b0);
    endtask

    task automatic pad();
        while (nlk % 32 != 0) tx(1'b0, 1'b0);
    endtask

    task automatic win(input logic [31:0] mask);
        for (int i = 0; i < 32; i++) tx(mask[i], 1'b0);
    endtask

    task automatic lock_seq(input string tag);
        for (int i = 1; i <= 24; i++) begin
            tx(1'b0, 1'b0);
            if (i == 7)  check({tag, "_seed7_state"}, 32'(state), 0);
            if (i == 8)  check({tag, "_seed8_state"}, 32'(state), 1);
            if (i == 23) check({tag, "_bit23_locked"}, 32'(locked), 0);
        end
        check({tag, "_bit24_locked"}, 32'(locked), 1);
        check({tag, "_bit24_state"}, 32'(state), 2);
        nlk = 0;
    endtask

    initial begin
        int         p0;
        int         cnt;
        logic [1:0] s;

        // 1: reset and first lock from generator state 0x80
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_state", 32'(state), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_err", 32'(err), 0);
        check("rst_count", 32'(err_count), 0);
        g = 8'h80;
        nlk = 0;
        pulses = 0;
        lock_seq("t1");
        check("t1_no_err", pulses, 0);
        check("t1_count", 32'(err_count), 0);

        // 2: single flipped bit
        repeat (10) tx(1'b0, 1'b0);
        p0 = pulses;
        tx(1'b1, 1'b0);
        check("t2_err_pulse", 32'(err), 1);
        check("t2_count", 32'(err_count), 1);
        tx(1'b0, 1'b0);
        check("t2_err_drop", 32'(err), 0);
        repeat (99) tx(1'b0, 1'b0);
        check("t2_one_pulse", pulses - p0, 1);
        check("t2_locked", 32'(locked), 1);
        check("t2_count_end", 32'(err_count), 1);

        // CLEAR alone with VALID low leaves state alone
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("clr_count", 32'(err_count), 0);
        check("clr_state", 32'(state), 2);

        // 3: errors at bits 2,9,15,20 of one window drop lock
        pad();
        p0 = pulses;
        for (int i = 0; i <= 20; i++) begin
            tx((i == 2) || (i == 9) || (i == 15) || (i == 20), 1'b0);
            if (i == 19) check("t3_still_locked", 32'(locked), 1);
        end
        check("t3_err", 32'(err), 1);
        check("t3_locked", 32'(locked), 0);
        check("t3_state", 32'(state), 0);
        check("t3_count", 32'(err_count), 4);
        check("t3_pulses", pulses - p0, 4);
        lock_seq("t3_relock");

        // errors at end of one window and start of the next do not combine
        pad();
        win(32'hE000_0000);
        win(32'h0000_0001);
        check("straddle_locked", 32'(locked), 1);
        check("straddle_count", 32'(err_count), 8);

        // 6: three errors per window for seven windows, saturation on the 4-bit copy
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("sat_clr", 32'(err_count_s), 0);
        pad();
        repeat (7) win(32'h4002_0020);
        check("sat_locked", 32'(locked), 1);
        check("sat_count16", 32'(err_count), 21);
        check("sat_count4", 32'(err_count_s), 15);
        tx(1'b1, 1'b1);
        check("clr_err_count16", 32'(err_count), 1);
        check("clr_err_count4", 32'(err_count_s), 1);
        check("clr_err_pulse", 32'(err), 1);

        // 4th error on the window's last bit still unlocks
        pad();
        for (int i = 0; i < 32; i++) begin
            tx(i >= 28, 1'b0);
            if (i == 30) check("prio_locked_b30", 32'(locked), 1);
        end
        check("prio_locked", 32'(locked), 0);
        check("prio_state", 32'(state), 0);
        check("prio_err", 32'(err), 1);
        check("prio_count", 32'(err_count), 5);

        // reset while in ACQUIRE
        repeat (10) tx(1'b0, 1'b0);
        check("acq_state", 32'(state), 1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("rst_acq_state", 32'(state), 0);
        check("rst_acq_locked", 32'(locked), 0);
        check("rst_acq_err", 32'(err), 0);
        check("rst_acq_count", 32'(err_count), 0);
        check("rst_acq_count4", 32'(err_count_s), 0);

        // 4: VALID every other cycle, random I on invalid cycles
        step(1'b0, 1'b0, 1'b0, 1'b1);
        g = 8'h80;
        for (int i = 1; i <= 24; i++) begin
            s = state;
            step(1'($urandom), 1'b0, 1'b0, 1'b0);
            check("t4_hold_state", 32'(state), 32'(s));
            check("t4_hold_err", 32'(err), 0);
            tx(1'b0, 1'b0);
            if (i == 7)  check("t4_seed7_state", 32'(state), 0);
            if (i == 8)  check("t4_seed8_state", 32'(state), 1);
            if (i == 23) check("t4_bit23_locked", 32'(locked), 0);
        end
        check("t4_bit24_locked", 32'(locked), 1);

        // 5: all-zero stream never leaves SEED, then ACQUIRE mismatch
        step(1'b0, 1'b0, 1'b0, 1'b1);
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (state !== 2'd0) cnt++;
        end
        check("t5_zero_state_cycles", cnt, 0);
        check("t5_zero_locked", 32'(locked), 0);
        check("t5_zero_count", 32'(err_count), 0);
        g = 8'h80;
        repeat (8) tx(1'b0, 1'b0);
        check("t5_acq", 32'(state), 1);
        repeat (5) tx(1'b0, 1'b0);
        tx(1'b1, 1'b0);
        check("t5_miss_state", 32'(state), 0);
        check("t5_miss_err", 32'(err), 0);
        lock_seq("t5_relock");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_checker8.md
Name: lfsr_checker8

Overview:
- Serial receive-side checker for the 8-bit Fibonacci LFSR stream our lfsr generator produces.
- Stream recurrence: b[n] = b[n-1] ^ b[n-3] ^ b[n-4] ^ b[n-5].
- Self-seeds from the incoming bits, acquires lock, then free-runs a local reference and counts bit errors.
- Sits at the far end of a serial link or loopback as the BIST/link-quality monitor.

Parameters:
LOCK_COUNT, 16, consecutive matching valid bits in ACQUIRE required to declare lock
WINDOW, 32, length of the loss-of-lock observation window, in valid bits while LOCKED
UNLOCK_ERRS, 4, errors within one window that force loss of lock (1..WINDOW)
ERR_W, 16, width of the error counter

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  synchronous, active-high reset
I  input  1  received serial bit
VALID  input  1  I is a valid stream bit this cycle; when low, no state changes except CLEAR and RESET
CLEAR  input  1  clears ERR_COUNT
LOCKED  output  1  high while in LOCKED state
ERR  output  1  one-cycle pulse per mismatched bit while LOCKED
ERR_COUNT  output  ERR_W  saturating count of LOCKED-state errors
STATE  output  2  0=SEED, 1=ACQUIRE, 2=LOCKED (3 unused)

Behaviour:
- Reset (RESET=1 at an edge): history=0, seed count=0, match count=0, window/error-in-window counters=0, STATE=SEED, LOCKED=0, ERR=0, ERR_COUNT=0. Reset mid-operation aborts immediately; RESET has priority over every input.
- History: 8-bit shift register h, h[0]=most recent bit. Prediction p = h[0]^h[2]^h[3]^h[4].
- SEED:
  - Each valid bit shifts I into h; seed count increments.
  - After the 8th valid bit: if the new h is non-zero, go to ACQUIRE; if zero, seed count returns to 0 and SEED continues. An all-zero stream never locks.
- ACQUIRE:
  - Each valid bit compares I to p and shifts I into h.
  - Match: match count increments. On reaching LOCK_COUNT, go to LOCKED.
  - Mismatch: go to SEED with seed count=0 and match count=0. h keeps shifting; it is not cleared.
  - No ERR pulses and no ERR_COUNT changes in SEED or ACQUIRE.
- LOCKED:
  - Each valid bit shifts p (not I) into h, so the reference free-runs and a single flipped bit yields exactly one error.
  - Mismatch (I != p): ERR=1 in the following cycle; ERR_COUNT increments, saturating at all-ones; error-in-window increments.
  - Window counter counts valid bits. When it reaches WINDOW, it and error-in-window reset to 0, including on the same edge as a counted error.
  - Error-in-window reaching UNLOCK_ERRS takes priority over window expiry: go to SEED (seed count=0, match count=0, window counters=0). LOCKED falls the same cycle STATE shows SEED. The ERR pulse for that last error is still produced.
- Latency: LOCKED, STATE, ERR and ERR_COUNT are registered and update one cycle after the valid bit that causes the change.
- CLEAR:
  - Alone: ERR_COUNT=0 at the next edge.
  - Coincident with a counted error: ERR_COUNT=1 (the error is not lost).
  - CLEAR does not affect state, history or window counters.
- VALID low: h, all counters and STATE hold; ERR=0.

Test Plan:
1. Reset, then drive 24 consecutive valid bits of a clean stream from generator state 0x80 → STATE 0→1 after bit 8; LOCKED=1 one cycle after bit 24; ERR never asserted; ERR_COUNT=0.
2. While locked, invert exactly one bit, then run 100 clean bits → exactly one ERR pulse, one cycle after the flipped bit; ERR_COUNT=1; LOCKED stays 1.
3. While locked, invert bits 2, 9, 15, 20 of one 32-bit window → ERR pulses 4 times, ERR_COUNT=4; LOCKED=0 and STATE=0 after the 4th; LOCKED returns one cycle after 24 further clean bits. Invert 3 bits per window over several windows instead → never loses lock.
4. Repeat scenario 1 with VALID high only every other cycle, with I randomized on invalid cycles → identical lock point measured in valid bits; no state change on invalid cycles.
5. Drive I=0 with VALID=1 for 64 cycles → STATE remains 0, LOCKED=0, ERR_COUNT=0. Then insert a mismatch during ACQUIRE → STATE returns to 0.
6. Set ERR_W=4 and force 20 errors while locked (windows permitting) → ERR_COUNT saturates at 15. Assert CLEAR together with an error → ERR_COUNT=1. Assert RESET during ACQUIRE → all outputs 0 at the next cycle.
